// File: rtl/gpio_apb_arbiter.sv
// Two-requester round-robin APB arbiter in front of a single APB completer.
// The request is latched at grant, and a programmable timeout forces an error completion.
module gpio_apb_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_paddr,
  input  logic                m0_psel,
  input  logic                m0_penable,
  input  logic [2:0]          m0_pprot,
  input  logic                m0_pwrite,
  input  logic [DATA_W-1:0]   m0_pwdata,
  input  logic [DATA_W/8-1:0] m0_pstrb,
  output logic                m0_pready,
  output logic [DATA_W-1:0]   m0_prdata,
  output logic                m0_pslverr,
  input  logic [ADDR_W-1:0]   m1_paddr,
  input  logic                m1_psel,
  input  logic                m1_penable,
  input  logic [2:0]          m1_pprot,
  input  logic                m1_pwrite,
  input  logic [DATA_W-1:0]   m1_pwdata,
  input  logic [DATA_W/8-1:0] m1_pstrb,
  output logic                m1_pready,
  output logic [DATA_W-1:0]   m1_prdata,
  output logic                m1_pslverr,
  output logic [ADDR_W-1:0]   out_paddr,
  output logic                out_psel,
  output logic                out_penable,
  output logic [2:0]          out_pprot,
  output logic                out_pwrite,
  output logic [DATA_W-1:0]   out_pwdata,
  output logic [DATA_W/8-1:0] out_pstrb,
  input  logic                out_pready,
  input  logic [DATA_W-1:0]   out_prdata,
  input  logic                out_pslverr
);

  localparam logic [15:0] TO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t            state;
  state_t            state_next;
  logic              grant;
  logic              last_served;
  logic [15:0]       tcount;
  logic              any_req;
  logic              pick;
  logic              timeout_hit;
  logic              done;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  // penable from the requesters carries no information the arbiter needs
  logic unused_penable;
  assign unused_penable = m0_penable ^ m1_penable;

  always_comb begin
    any_req     = m0_psel | m1_psel;
    // On a tie the requester that was not served last wins; otherwise whoever asks
    pick        = (m0_psel && m1_psel) ? ~last_served : m1_psel;
    timeout_hit = (TIMEOUT != 0) && (tcount == TO_LAST);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (out_pready || timeout_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant       <= 1'b0;
      last_served <= 1'b1;
      tcount      <= 16'd0;
      out_paddr   <= '0;
      out_pprot   <= '0;
      out_pwrite  <= 1'b0;
      out_pwdata  <= '0;
      out_pstrb   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant <= pick;
            if (pick) begin
              out_paddr  <= m1_paddr;
              out_pprot  <= m1_pprot;
              out_pwrite <= m1_pwrite;
              out_pwdata <= m1_pwdata;
              out_pstrb  <= m1_pstrb;
            end else begin
              out_paddr  <= m0_paddr;
              out_pprot  <= m0_pprot;
              out_pwrite <= m0_pwrite;
              out_pwdata <= m0_pwdata;
              out_pstrb  <= m0_pstrb;
            end
          end
        end
        SETUP: tcount <= 16'd0;
        ACCESS: begin
          if (out_pready || timeout_hit) last_served <= grant;
          else                           tcount      <= tcount + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Response is combinational so the requester completes in the same cycle as the completer
  always_comb begin
    out_psel    = (state != IDLE);
    out_penable = (state == ACCESS);
    done        = (state == ACCESS) && (out_pready || timeout_hit);
    rsp_rdata   = out_pready ? out_prdata : '0;
    rsp_err     = out_pready ? out_pslverr : 1'b1;
    m0_pready   = done && !grant;
    m1_pready   = done && grant;
    m0_prdata   = m0_pready ? rsp_rdata : '0;
    m1_prdata   = m1_pready ? rsp_rdata : '0;
    m0_pslverr  = m0_pready ? rsp_err : 1'b0;
    m1_pslverr  = m1_pready ? rsp_err : 1'b0;
  end

endmodule

// File: tb/tb_gpio_apb_arbiter.sv
// Directed bench for gpio_apb_arbiter: scoreboard of expected responses checked by a monitor,
// plus a second instance with a short timeout.
module tb_gpio_apb_arbiter;

  localparam int EW = 114;

  typedef struct packed {
    logic        id;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [15:0] cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic [EW-1:0] exp_q[$];

  // main instance signals
  logic [31:0] m0_paddr, m1_paddr, m0_pwdata, m1_pwdata;
  logic        m0_psel, m1_psel, m0_penable, m1_penable, m0_pwrite, m1_pwrite;
  logic [2:0]  m0_pprot, m1_pprot;
  logic [3:0]  m0_pstrb, m1_pstrb;
  logic        m0_pready, m1_pready, m0_pslverr, m1_pslverr;
  logic [31:0] m0_prdata, m1_prdata;
  logic [31:0] out_paddr, out_pwdata;
  logic        out_psel, out_penable, out_pwrite;
  logic [2:0]  out_pprot;
  logic [3:0]  out_pstrb;
  logic        out_pready = 1'b0;
  logic [31:0] out_prdata = 32'h0;
  logic        out_pslverr = 1'b0;

  // timeout instance signals
  logic [31:0] t_m0_paddr, t_m1_paddr, t_m0_pwdata, t_m1_pwdata;
  logic        t_m0_psel, t_m1_psel, t_m0_penable, t_m1_penable, t_m0_pwrite, t_m1_pwrite;
  logic [2:0]  t_m0_pprot, t_m1_pprot;
  logic [3:0]  t_m0_pstrb, t_m1_pstrb;
  logic        t_m0_pready, t_m1_pready, t_m0_pslverr, t_m1_pslverr;
  logic [31:0] t_m0_prdata, t_m1_prdata;
  logic [31:0] t_out_paddr, t_out_pwdata;
  logic        t_out_psel, t_out_penable, t_out_pwrite;
  logic [2:0]  t_out_pprot;
  logic [3:0]  t_out_pstrb;
  logic        t_out_pready, t_out_pslverr;
  logic [31:0] t_out_prdata;

  int          cmp_wait = 0;
  int          acc_cnt = 0;
  logic [31:0] cmp_rdata = 32'h0;
  logic        cmp_err = 1'b0;

  gpio_apb_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(256)) dut (
    .clock(clock), .reset(reset),
    .m0_paddr(m0_paddr), .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pprot(m0_pprot),
    .m0_pwrite(m0_pwrite), .m0_pwdata(m0_pwdata), .m0_pstrb(m0_pstrb),
    .m0_pready(m0_pready), .m0_prdata(m0_prdata), .m0_pslverr(m0_pslverr),
    .m1_paddr(m1_paddr), .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pprot(m1_pprot),
    .m1_pwrite(m1_pwrite), .m1_pwdata(m1_pwdata), .m1_pstrb(m1_pstrb),
    .m1_pready(m1_pready), .m1_prdata(m1_prdata), .m1_pslverr(m1_pslverr),
    .out_paddr(out_paddr), .out_psel(out_psel), .out_penable(out_penable), .out_pprot(out_pprot),
    .out_pwrite(out_pwrite), .out_pwdata(out_pwdata), .out_pstrb(out_pstrb),
    .out_pready(out_pready), .out_prdata(out_prdata), .out_pslverr(out_pslverr)
  );

  gpio_apb_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut_to (
    .clock(clock), .reset(reset),
    .m0_paddr(t_m0_paddr), .m0_psel(t_m0_psel), .m0_penable(t_m0_penable), .m0_pprot(t_m0_pprot),
    .m0_pwrite(t_m0_pwrite), .m0_pwdata(t_m0_pwdata), .m0_pstrb(t_m0_pstrb),
    .m0_pready(t_m0_pready), .m0_prdata(t_m0_prdata), .m0_pslverr(t_m0_pslverr),
    .m1_paddr(t_m1_paddr), .m1_psel(t_m1_psel), .m1_penable(t_m1_penable), .m1_pprot(t_m1_pprot),
    .m1_pwrite(t_m1_pwrite), .m1_pwdata(t_m1_pwdata), .m1_pstrb(t_m1_pstrb),
    .m1_pready(t_m1_pready), .m1_prdata(t_m1_prdata), .m1_pslverr(t_m1_pslverr),
    .out_paddr(t_out_paddr), .out_psel(t_out_psel), .out_penable(t_out_penable), .out_pprot(t_out_pprot),
    .out_pwrite(t_out_pwrite), .out_pwdata(t_out_pwdata), .out_pstrb(t_out_pstrb),
    .out_pready(t_out_pready), .out_prdata(t_out_prdata), .out_pslverr(t_out_pslverr)
  );

  // clock / reset-relative cycle counter
  always #5 clock = ~clock;

  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // completer model: ready on ACCESS cycle index cmp_wait
  always @(posedge clock) begin
    #1;
    if (!reset && out_psel && out_penable) begin
      out_pready = (acc_cnt >= cmp_wait);
      acc_cnt++;
    end else begin
      out_pready = 1'b0;
      acc_cnt = 0;
    end
    out_prdata  = cmp_rdata;
    out_pslverr = out_pready ? cmp_err : 1'b0;
  end

  // monitor / scoreboard
  always @(negedge clock) begin
    exp_t e;
    if (!reset && (m0_pready || m1_pready)) begin
      check("single_ready", {63'd0, m0_pready & m1_pready}, 64'd0);
      check("out_pready_at_ready", {63'd0, out_pready}, 64'd1);
      check("out_penable_at_ready", {63'd0, out_penable}, 64'd1);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready m0=%0b m1=%0b required=none", m0_pready, m1_pready);
      end else begin
        e = exp_t'(exp_q.pop_front());
        check("rsp_id", {63'd0, m1_pready}, {63'd0, e.id});
        check("rsp_rdata", m1_pready ? m1_prdata : m0_prdata, e.rdata);
        check("rsp_err", m1_pready ? m1_pslverr : m0_pslverr, e.err);
        check("out_paddr", out_paddr, e.paddr);
        check("out_pwdata", out_pwdata, e.pwdata);
        check("rsp_cycle", cyc[15:0], e.cyc);
        check("peer_prdata", m1_pready ? m0_prdata : m1_prdata, 64'd0);
        check("peer_pslverr", m1_pready ? m0_pslverr : m1_pslverr, 64'd0);
      end
    end
  end

  task automatic push_exp(input logic id, input logic err, input logic [31:0] rd,
                          input logic [31:0] ad, input logic [31:0] wd, input int c);
    exp_q.push_back({id, err, rd, ad, wd, 16'(c)});
  endtask

  task automatic wait_drain(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      #2;
      if (exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t required=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    reset = 1'b1;
    {m0_paddr, m1_paddr, m0_pwdata, m1_pwdata} = '0;
    {m0_psel, m1_psel, m0_penable, m1_penable, m0_pwrite, m1_pwrite} = '0;
    {m0_pprot, m1_pprot, m0_pstrb, m1_pstrb} = '0;
    {t_m0_paddr, t_m1_paddr, t_m0_pwdata, t_m1_pwdata} = '0;
    {t_m0_psel, t_m1_psel, t_m0_penable, t_m1_penable, t_m0_pwrite, t_m1_pwrite} = '0;
    {t_m0_pprot, t_m1_pprot, t_m0_pstrb, t_m1_pstrb} = '0;
    t_out_pready = 1'b0;
    t_out_pslverr = 1'b0;
    t_out_prdata = 32'hDEAD_BEEF;
    repeat (2) @(negedge clock);

    // reset state
    check("rst_out_psel", out_psel, 0);
    check("rst_out_penable", out_penable, 0);
    check("rst_out_paddr", out_paddr, 0);
    check("rst_m0_pready", m0_pready, 0);
    check("rst_m1_prdata", m1_prdata, 0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_out_psel", out_psel, 0);

    // single write from m0, zero-wait completer
    c0 = cyc;
    m0_paddr = 32'h1000_2000; m0_pwdata = 32'h0000_A5A5; m0_pstrb = 4'b0011;
    m0_pwrite = 1'b1; m0_psel = 1'b1;
    push_exp(1'b0, 1'b0, 32'h0, 32'h1000_2000, 32'h0000_A5A5, c0 + 2);
    @(negedge clock);
    check("t1_setup_psel", out_psel, 1);
    check("t1_setup_penable", out_penable, 0);
    check("t1_out_pstrb", out_pstrb, 4'b0011);
    wait_drain(20);
    m0_psel = 1'b0;
    @(negedge clock);

    // read forwarding to m1
    c0 = cyc;
    cmp_rdata = 32'h0000_1234;
    m1_paddr = 32'h1000_2000; m1_pwrite = 1'b0; m1_pwdata = 32'h0; m1_psel = 1'b1;
    push_exp(1'b1, 1'b0, 32'h0000_1234, 32'h1000_2000, 32'h0, c0 + 2);
    wait_drain(20);
    m1_psel = 1'b0;
    @(negedge clock);

    // completer error is forwarded
    c0 = cyc;
    cmp_rdata = 32'h0000_0BAD; cmp_err = 1'b1;
    m1_paddr = 32'h1000_2008; m1_psel = 1'b1;
    push_exp(1'b1, 1'b1, 32'h0000_0BAD, 32'h1000_2008, 32'h0, c0 + 2);
    wait_drain(20);
    m1_psel = 1'b0;
    cmp_rdata = 32'h0; cmp_err = 1'b0;
    @(negedge clock);

    // contention from reset: strict alternation, 3 cycles apart
    do_reset();
    c0 = cyc;
    m0_paddr = 32'h1000_2000; m0_pwdata = 32'h0000_0011; m0_pwrite = 1'b1;
    m1_paddr = 32'h1000_2008; m1_pwdata = 32'h0000_0022; m1_pwrite = 1'b1;
    m0_psel = 1'b1; m1_psel = 1'b1;
    push_exp(1'b0, 1'b0, 32'h0, 32'h1000_2000, 32'h11, c0 + 2);
    push_exp(1'b1, 1'b0, 32'h0, 32'h1000_2008, 32'h22, c0 + 5);
    push_exp(1'b0, 1'b0, 32'h0, 32'h1000_2000, 32'h11, c0 + 8);
    push_exp(1'b1, 1'b0, 32'h0, 32'h1000_2008, 32'h22, c0 + 11);
    wait_drain(40);
    m0_psel = 1'b0; m1_psel = 1'b0;
    @(negedge clock);

    // wait states; requester fields change after grant
    cmp_wait = 5;
    c0 = cyc;
    m0_paddr = 32'h1000_2008; m0_pwdata = 32'h0000_00C3; m0_psel = 1'b1;
    push_exp(1'b0, 1'b0, 32'h0, 32'h1000_2008, 32'h0000_00C3, c0 + 7);
    @(negedge clock);
    m0_paddr = 32'hFFFF_FFF0; m0_pwdata = 32'h5555_5555;
    wait_drain(30);
    m0_psel = 1'b0;
    cmp_wait = 0;
    @(negedge clock);

    // timeout instance (TIMEOUT=4), completer never ready
    t_m0_paddr = 32'h1000_2000; t_m0_psel = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("to_early_pready", t_m0_pready, 0);
    end
    @(negedge clock);
    check("to_pready", t_m0_pready, 1);
    check("to_pslverr", t_m0_pslverr, 1);
    check("to_prdata", t_m0_prdata, 0);
    t_m0_psel = 1'b0;
    @(negedge clock);
    check("to_next_psel", t_out_psel, 0);

    // reset asserted while a response is being presented
    cmp_wait = 2;
    m0_paddr = 32'h1000_2000; m0_pwdata = 32'h0000_0077; m0_psel = 1'b1;
    repeat (4) @(posedge clock);
    #3;
    check("pre_rst_m0_pready", m0_pready, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_out_psel", out_psel, 0);
    check("mid_rst_out_penable", out_penable, 0);
    check("mid_rst_m0_pready", m0_pready, 0);
    check("mid_rst_m1_pready", m1_pready, 0);
    check("mid_rst_out_paddr", out_paddr, 0);
    m1_psel = 1'b1;
    cmp_wait = 0;
    @(negedge clock);
    reset = 1'b0;
    c0 = cyc;
    m1_paddr = 32'h1000_2008; m1_pwdata = 32'h0000_0088;
    push_exp(1'b0, 1'b0, 32'h0, 32'h1000_2000, 32'h77, c0 + 2);
    push_exp(1'b1, 1'b0, 32'h0, 32'h1000_2008, 32'h88, c0 + 5);
    wait_drain(20);
    m0_psel = 1'b0; m1_psel = 1'b0;
    repeat (2) @(negedge clock);

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
